adder_arbiter: RTL and testbench

//  Shares one combinational `adder` instance (WIDTH-bit in, WIDTH+1-bit out) between
//  NUM_REQ requesters, using round-robin arbitration.

---
 rtl/adder_arb_pkg.sv | 33 +++
 rtl/adder_arbiter_adder.sv | 21 ++
 rtl/adder_arbiter.sv | 109 ++++++++++
 tb/tb_adder_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the round-robin adder arbiter.
//   WIDTH_DEF / NUM_REQ_DEF : default operand width and requester count
//   MAX_REQ                 : widest request vector rr_pick can handle
//   out_state_t             : output register occupancy
//   rr_pick                 : round-robin one-hot grant over a valid vector
package adder_arb_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int NUM_REQ_DEF = 4;
    localparam int MAX_REQ     = 32;

    typedef enum logic {EMPTY, FULL} out_state_t;

    // Scan n requesters starting at ptr, wrapping at n-1 -> 0; the first valid
    // one found wins. Returns all-zero when nothing is valid.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int unsigned        ptr,
                                                   input int unsigned        n);
        logic [MAX_REQ-1:0] g;
        logic [4:0]         idx;
        g = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = 5'((ptr + k) % n);
                if ((g == '0) && valid[idx]) begin
                    g[idx] = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Shared combinational adder.
//   en  : when low the sum is forced to zero
//   a,b : WIDTH-bit operands
//   sum : WIDTH+1-bit zero-extended sum, bit WIDTH is the carry
module adder #(
    parameter int WIDTH = 16
) (
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    always_comb begin
        sum = '0;
        if (en) begin
            sum = {1'b0, a} + {1'b0, b};
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between NUM_REQ requesters.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is combinational)
//   req_a, req_b      : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready   : result register handshake
//   rsp_id, rsp_sum   : owner of the held result and its {carry, sum}
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*WIDTH-1:0]    req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [WIDTH:0]              rsp_sum
);

    localparam int ID_W = $clog2(NUM_REQ);

    out_state_t        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH:0]    rsp_sum_q, rsp_sum_d;

    logic [MAX_REQ-1:0] pick;
    logic [NUM_REQ-1:0] gnt;
    logic               can_accept;
    logic               accept;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [ID_W-1:0]    sel_id;
    logic [WIDTH:0]     add_sum;

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

    // Grant depends only on valids and the pointer, never on operand data.
    always_comb begin
        pick       = rr_pick(MAX_REQ'(req_valid), 32'(rr_ptr_q), 32'(NUM_REQ));
        gnt        = pick[NUM_REQ-1:0];
        can_accept = (state_q == EMPTY) | (rsp_valid & rsp_ready);
        req_ready  = '0;
        if (!rst && can_accept) begin
            req_ready = gnt;
        end
        accept = |(req_valid & req_ready);
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_id = ID_W'(i);
            end
        end
    end

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .en  (1'b1),
        .a   (sel_a),
        .b   (sel_b),
        .sum (add_sum)
    );

    // An accept while FULL is only possible when the old result drains in the
    // same cycle, so overwriting it keeps one sum per cycle.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        rsp_id_d  = rsp_id_q;
        rsp_sum_d = rsp_sum_q;
        if (accept) begin
            state_d   = FULL;
            rsp_sum_d = add_sum;
            rsp_id_d  = sel_id;
            rr_ptr_d  = ID_W'((32'(sel_id) + 32'd1) % 32'(NUM_REQ));
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            rr_ptr_q  <= '0;
            rsp_id_q  <= '0;
            rsp_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_id_q  <= rsp_id_d;
            rsp_sum_q <= rsp_sum_d;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W:0]      rsp_sum;

    int vectors;
    int miscompares;

    adder_arbiter #(
        .WIDTH   (W),
        .NUM_REQ (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, W'(i + 1), W'(i + 1));
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_sum !== 17'h0) begin
                $display("FAIL reset_hold: rsp_valid=%b req_ready=%b rsp_sum=%h, want 0/0000/00000",
                         rsp_valid, req_ready, rsp_sum);
                miscompares++;
            end
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL reset_first_grant: req_ready=%b want 0001", req_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 17'h00002) begin
            $display("FAIL reset_first_rsp: valid=%b id=%0d sum=%h want 1/0/00002",
                     rsp_valid, rsp_id, rsp_sum);
            miscompares++;
        end
        drain();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL reset_drain: rsp_valid=%b want 0", rsp_valid);
            miscompares++;
        end
    endtask

    // Pointer is 1 here; req0 alone still wins after wrapping.
    task automatic test_single();
        set_op(0, 16'h0003, 16'h0004);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL single_ready: req_ready=%b want 0001", req_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 17'h00007) begin
            $display("FAIL single_rsp: valid=%b id=%0d sum=%h want 1/0/00007",
                     rsp_valid, rsp_id, rsp_sum);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_carry();
        set_op(0, 16'hFFFF, 16'h0001);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 17'h10000) begin
            $display("FAIL carry_ffff_1: valid=%b sum=%h want 1/10000", rsp_valid, rsp_sum);
            miscompares++;
        end
        set_op(0, 16'hFFFF, 16'hFFFF);
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 17'h1FFFE) begin
            $display("FAIL carry_ffff_ffff: valid=%b sum=%h want 1/1FFFE", rsp_valid, rsp_sum);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ids [6];
        logic [W:0] exp_sum;
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, W'(16'h1000 * (i + 1)), W'(i + 1));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_sum = 17'(16'h1000 * (exp_ids[c] + 1)) + 17'(exp_ids[c] + 1);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_ids[c] || rsp_sum !== exp_sum) begin
                $display("FAIL rr_seq[%0d]: valid=%b id=%0d sum=%h want 1/%0d/%h",
                         c, rsp_valid, rsp_id, rsp_sum, exp_ids[c], exp_sum);
                miscompares++;
            end
        end
        req_valid = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
                $display("FAIL rr_burst2[%0d]: valid=%b id=%0d want 1/2", c, rsp_valid, rsp_id);
                miscompares++;
            end
        end
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            $display("FAIL rr_after_burst: req_ready=%b want 1000", req_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (rsp_id !== 2'd3) begin
            $display("FAIL rr_after_burst_id: id=%0d want 3", rsp_id);
            miscompares++;
        end
        drain();
    endtask

    // Pointer is 0 on entry.
    task automatic test_backpressure();
        set_op(1, 16'h0005, 16'h0006);
        set_op(2, 16'h0007, 16'h0008);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        tick();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0000) begin
                $display("FAIL bp_ready[%0d]: req_ready=%b want 0000", c, req_ready);
                miscompares++;
            end
            tick();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 17'h0000B) begin
                $display("FAIL bp_hold[%0d]: valid=%b id=%0d sum=%h want 1/1/0000B",
                         c, rsp_valid, rsp_id, rsp_sum);
                miscompares++;
            end
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL bp_release_ready: req_ready=%b want 0100", req_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 17'h0000F) begin
            $display("FAIL bp_release_rsp: valid=%b id=%0d sum=%h want 1/2/0000F",
                     rsp_valid, rsp_id, rsp_sum);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_reset_midop();
        set_op(3, 16'h0009, 16'h0001);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 17'h0000A) begin
            $display("FAIL midop_full: valid=%b id=%0d sum=%h want 1/3/0000A",
                     rsp_valid, rsp_id, rsp_sum);
            miscompares++;
        end
        rst       = 1'b1;
        req_valid = 4'b1000;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL midop_rst_ready: req_ready=%b want 0000", req_ready);
            miscompares++;
        end
        tick();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 17'h0) begin
            $display("FAIL midop_cleared: valid=%b id=%0d sum=%h want 0/0/00000",
                     rsp_valid, rsp_id, rsp_sum);
            miscompares++;
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                $display("FAIL midop_stale[%0d]: rsp_valid=%b want 0", c, rsp_valid);
                miscompares++;
            end
        end
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL midop_ptr: req_ready=%b want 0001", req_ready);
            miscompares++;
        end
        tick();
        req_valid = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
